// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame debounce.
// Ports: clk, rst (async active-low), row/col matrix, key/key_valid/key_held/number.
module keypad_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [3:0]  key,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] number
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] C_SAT = CW'(DEBOUNCE);

  typedef enum logic {
    ST_NONE,
    ST_KEY
  } stab_e;

  logic [3:0]    sync1, cs;
  logic [PW-1:0] presc, presc_n;
  logic [1:0]    ridx, ridx_n;
  logic [11:0]   fbits, fbits_n;
  logic          cand_hit, cand_hit_n;
  logic [3:0]    cand_code, cand_code_n;
  logic [CW-1:0] cnt, cnt_n;
  stab_e         st, st_n;
  logic [3:0]    st_code, st_code_n;
  logic [3:0]    row_n, key_n;
  logic          valid_n, held_n;
  logic [15:0]   number_n;

  logic          tick, fend;
  logic [15:0]   all_bits;
  logic [4:0]    ones;
  logic          res_hit;
  logic [3:0]    res_code;
  logic          differs;

  assign tick = (presc == P_LAST);
  assign fend = tick && (ridx == 2'd3);

  // Row 3 is never stored: its sample is taken live on the frame-end tick.
  always_comb begin
    all_bits = {~cs, fbits};
    ones     = '0;
    res_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (all_bits[i]) begin
        ones     = ones + 5'd1;
        res_code = 4'(i);
      end
    end
    res_hit = (ones == 5'd1);
    if (!res_hit) res_code = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= '0;
      cs        <= '0;
      presc     <= '0;
      ridx      <= '0;
      fbits     <= '0;
      cand_hit  <= 1'b0;
      cand_code <= '0;
      cnt       <= '0;
      st        <= ST_NONE;
      st_code   <= '0;
      row       <= 4'b0111;
      key       <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      number    <= '0;
    end else begin
      sync1     <= col;
      cs        <= sync1;
      presc     <= presc_n;
      ridx      <= ridx_n;
      fbits     <= fbits_n;
      cand_hit  <= cand_hit_n;
      cand_code <= cand_code_n;
      cnt       <= cnt_n;
      st        <= st_n;
      st_code   <= st_code_n;
      row       <= row_n;
      key       <= key_n;
      key_valid <= valid_n;
      key_held  <= held_n;
      number    <= number_n;
    end
  end

  always_comb begin
    presc_n     = tick ? '0 : presc + 1'b1;
    ridx_n      = tick ? ridx + 2'd1 : ridx;
    fbits_n     = fbits;
    cand_hit_n  = cand_hit;
    cand_code_n = cand_code;
    cnt_n       = cnt;
    st_n        = st;
    st_code_n   = st_code;
    key_n       = key;
    number_n    = number;
    valid_n     = 1'b0;
    held_n      = key_held;
    differs     = 1'b0;

    if (tick) begin
      case (ridx)
        2'd0:    fbits_n[3:0]  = ~cs;
        2'd1:    fbits_n[7:4]  = ~cs;
        2'd2:    fbits_n[11:8] = ~cs;
        default: ;
      endcase
    end

    if (fend) begin
      if (res_hit == cand_hit && res_code == cand_code) begin
        if (cnt != C_SAT) cnt_n = cnt + 1'b1;
      end else begin
        cand_hit_n  = res_hit;
        cand_code_n = res_code;
        cnt_n       = CW'(1);
      end
      // NONE is held with code 0, so a plain compare catches every change.
      differs = (cand_hit_n != (st == ST_KEY)) ||
                (cand_code_n != st_code);
      if (cnt_n == C_SAT && differs) begin
        if (cand_hit_n) begin
          st_n      = ST_KEY;
          st_code_n = cand_code_n;
          key_n     = cand_code_n;
          number_n  = {number[11:0], cand_code_n};
          valid_n   = 1'b1;
          held_n    = 1'b1;
        end else begin
          st_n      = ST_NONE;
          st_code_n = '0;
          held_n    = 1'b0;
        end
      end
    end

    unique case (ridx_n)
      2'd0:    row_n = 4'b0111;
      2'd1:    row_n = 4'b1011;
      2'd2:    row_n = 4'b1101;
      default: row_n = 4'b1110;
    endcase
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad scanner for a 4x4 hexadecimal keypad. It is the input-side counterpart of the multiplexed 7-segment display driver. It strobes the four keypad rows one at a time, using the same active-low one-hot rotation the display uses on its anodes, and samples the four column lines. Each full scan frame is debounced. Each accepted key press is emitted as a 4-bit code with a one-cycle strobe and is also shifted into a 16-bit register that feeds the display's `number` input directly.

## Interface
- `SCAN_DIV`, 50000: clock cycles each row stays driven (dwell). Must be >= 4.
- `DEBOUNCE`, 4: consecutive identical frame results needed to accept a change. Must be >= 1.

- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-low (0 = reset)
- `row`  out  4  row drive, active-low one-hot
- `col`  in  4  column sense, active-low, pulled up externally; asynchronous to `clk`
- `key`  out  4  code of the last accepted key
- `key_valid`  out  1  one-cycle pulse per accepted press
- `key_held`  out  1  high while the accepted key remains pressed
- `number`  out  16  last four accepted codes, newest in `[3:0]`

## Operation
- Reset values:
  - `row`=4'b0111, `key`=0, `key_valid`=0, `key_held`=0, `number`=16'h0000.
  - Prescaler, row index, stability counter and synchroniser flops all 0.
  - Stable state = NONE.
  - Asserting reset mid-scan or mid-debounce aborts immediately, with no strobe.
- `col` passes through a 2-flop synchroniser. All decisions use the synchronised value `cs`.
- Prescaler counts 0..SCAN_DIV-1 and wraps. The cycle with prescaler == SCAN_DIV-1 is the *tick*.
- Row index r cycles 0,1,2,3,0 and advances on each tick. `row` per r: 0→4'b0111, 1→4'b1011, 2→4'b1101, 3→4'b1110.
- On each tick, `~cs` is stored as the 4 frame bits for the current r, before r advances.
- Frame end is the tick with r==3. Its result is computed from rows 0-2 (stored) plus the row-3 sample on that tick:
  - No bits set: NONE.
  - Exactly one bit set at row r, column c (c = bit index in `col`): KEY(code = 4*r + c).
  - Two or more bits set: treated as NONE, so no ghost or rollover codes are produced.
- Debounce, evaluated at every frame end:
  - Candidate = last frame result. If the new result equals the candidate, the stability counter increments, saturating at DEBOUNCE. Otherwise the candidate is replaced and the counter is set to 1.
  - When the counter equals DEBOUNCE and the candidate differs from the stable state, the candidate becomes the stable state.
- Stable-state transitions:
  - NONE→KEY(k): `key`<=k, `number`<={number[11:0],k}, `key_valid` pulses, `key_held`<=1.
  - KEY→NONE: `key_held`<=0. `key` and `number` are unchanged and there is no pulse.
  - KEY(j)→KEY(k), k≠j: handled as a new press, with the same updates as NONE→KEY(k).

## Timing
- Row dwell is SCAN_DIV cycles. Frame period is 4*SCAN_DIV cycles.
- All outputs are registered. `key`, `number`, `key_held` and `key_valid` update at the clock edge ending the accepting frame-end tick. `key_valid` is high for exactly the following cycle.
- Press latency depends on press phase:
  - Minimum (press stable before row dwell start, DEBOUNCE=1): 1 frame.
  - Maximum: DEBOUNCE+1 frames.
  - Plus 2 cycles of synchroniser delay.
- Release latency is the same as press latency.
- `key_valid` never asserts on two consecutive cycles. Consecutive pulses are at least DEBOUNCE frames apart.
- When the prescaler wraps and r wraps 3→0 in the same cycle, no frame bit may be lost. Row 0 of the new frame is sampled on its own tick.

## Test plan
Bench models the keypad: `col[c]`=0 iff `row[r]`=0 and key(r,c) is pressed. Use SCAN_DIV=4, DEBOUNCE=2 (frame = 16 cycles).
- Reset: pulse `rst`=0 for 3 cycles mid-dwell → `row`=4'b0111, `key`=0, `key_valid`=0, `key_held`=0, `number`=16'h0000 immediately. Scan resumes at r=0.
- Row rotation, no keys pressed → `row` steps 0111,1011,1101,1110 every 4 cycles and repeats; no `key_valid` over 10 frames.
- Press (r1,c2) at a frame start and hold 4 frames → exactly one `key_valid` pulse after the 2nd frame end, `key`=6, `number`=16'h0006, `key_held`=1. Release → `key_held`=0 after the 2nd NONE frame end, with no pulse.
- Bounce: (r0,c1) pressed on alternate frames for 8 frames → no `key_valid`, `key_held` stays 0.
- Two keys (r0,c0)+(r2,c3) pressed together for 4 frames → no pulse. Hold (r2,c3) alone until accepted (`key`=11, `key_held`=1), then add (r0,c0) → `key_held` falls after 2 frames.
- Sequence: press/release codes 1, 2, 3, 10, 15, each held and released for 3 frames → five pulses, final `number`=16'h23AF, `key`=4'hF.
